srl_fifo_param: RTL and testbench

//  Parametrised shift-register FIFO: generalised width/depth, occupancy count, programmable

---
 rtl/srl_fifo_param.sv | 141 ++++++++++++++
 tb/tb_srl_fifo_param.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/srl_fifo_param.sv
// Parametrised shift-register FIFO with show-ahead read data, occupancy count and level flags.
// Optional sticky overflow/underflow error flags are built when SRL_FIFO_ERR_EN is defined.
module srl_fifo_param #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned AF_LEVEL   = (2 ** DEPTH_LOG2) - 2,
    parameter int unsigned AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr,
    input  logic                  rd,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam int unsigned AW    = DEPTH_LOG2;

    logic [WIDTH-1:0] shr [DEPTH];

    logic [CW-1:0] count_q, count_next;
    logic [CW-1:0] rp_q, rp_next;
    logic          empty_q, empty_next;
    logic          full_q, full_next;
    logic          ae_q, ae_next;
    logic          af_q, af_next;

    logic wr_acc;
    logic rd_acc;

    // Full accepts a write only when a simultaneous read frees the oldest slot.
    assign wr_acc = wr & (~full_q | rd);
    assign rd_acc = rd & ~empty_q;

    // Storage shifts only on writes; reads just move the pointer.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            shr[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                shr[i] <= shr[i-1];
            end
        end
    end

    assign dout = shr[rp_q[AW-1:0]];

    always_comb begin
        count_next = count_q;
        rp_next    = rp_q;
        if (wr_acc && !rd_acc) begin
            count_next = count_q + CW'(1);
            rp_next    = rp_q + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_next = count_q - CW'(1);
            rp_next    = rp_q - CW'(1);
        end
        empty_next = (count_next == CW'(0));
        full_next  = (count_next == CW'(DEPTH));
        ae_next    = (count_next <= CW'(AE_LEVEL));
        af_next    = (count_next >= CW'(AF_LEVEL));
    end

    // Flags are registered alongside count so they switch in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            rp_q    <= '1;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ae_q    <= 1'b1;
            af_q    <= (AF_LEVEL == 0);
        end else begin
            count_q <= count_next;
            rp_q    <= rp_next;
            empty_q <= empty_next;
            full_q  <= full_next;
            ae_q    <= ae_next;
            af_q    <= af_next;
        end
    end

    assign count        = count_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_empty = ae_q;
    assign almost_full  = af_q;

`ifdef SRL_FIFO_ERR_EN
    logic ovf_q, ovf_next;
    logic unf_q, unf_next;

    // Any rejected access sets its flag; a set wins over a same-cycle clear.
    always_comb begin
        ovf_next = ovf_q;
        unf_next = unf_q;
        if (err_clr) begin
            ovf_next = 1'b0;
            unf_next = 1'b0;
        end
        if (wr && full_q && !rd) begin
            ovf_next = 1'b1;
        end
        if (rd && empty_q) begin
            unf_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_next;
            unf_q <= unf_next;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;

    logic unused_rp_msb;
    assign unused_rp_msb = rp_q[CW-1];
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;

    logic [1:0] unused_bits;
    assign unused_bits = {err_clr, rp_q[CW-1]};
`endif

endmodule

// File: tb/tb_srl_fifo_param.sv
// Directed self-checking bench for srl_fifo_param (WIDTH=8, DEPTH=16, AF=14, AE=2).
module tb_srl_fifo_param;

`ifdef SRL_FIFO_ERR_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr, rd, err_clr;
    logic [7:0] din;
    logic [7:0] dout;
    logic [4:0] count;
    logic       empty, full, almost_empty, almost_full, overflow, underflow;

    int checks = 0;
    int errors = 0;

    srl_fifo_param #(
        .WIDTH(8), .DEPTH_LOG2(4), .AF_LEVEL(14), .AE_LEVEL(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr(wr), .rd(rd), .din(din), .dout(dout),
        .count(count), .empty(empty), .full(full), .almost_empty(almost_empty),
        .almost_full(almost_full), .overflow(overflow), .underflow(underflow),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one clock of stimulus at negedge and return at the next negedge.
    task automatic cyc(input logic w, input logic r, input logic [7:0] d);
        wr  = w;
        rd  = r;
        din = d;
        @(posedge clk);
        @(negedge clk);
        wr  = 1'b0;
        rd  = 1'b0;
    endtask

    task automatic chk_level(input string tag, input int n);
        chk({tag, "_count"}, 32'(count), 32'(n));
        chk({tag, "_empty"}, 32'(empty), 32'(n == 0));
        chk({tag, "_full"},  32'(full),  32'(n == 16));
        chk({tag, "_ae"},    32'(almost_empty), 32'(n <= 2));
        chk({tag, "_af"},    32'(almost_full),  32'(n >= 14));
    endtask

    initial begin
        rst_n = 1'b0; wr = 1'b0; rd = 1'b0; err_clr = 1'b0; din = 8'h00;
        #12;
        chk_level("reset", 0);
        chk("reset_ovf", 32'(overflow), 32'(0));
        chk("reset_unf", 32'(underflow), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Empty with simultaneous write and read: write wins, read rejected.
        cyc(1'b1, 1'b1, 8'h55);
        chk_level("wr_rd_empty", 1);
        chk("wr_rd_empty_dout", 32'(dout), 32'h55);
        chk("wr_rd_empty_unf", 32'(underflow), 32'(ERR));
        err_clr = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        err_clr = 1'b0;
        chk("unf_clr", 32'(underflow), 32'(0));
        cyc(1'b0, 1'b1, 8'h00);
        chk_level("drain55", 0);

        // Empty, read only: nothing moves; error set beats a same-cycle clear.
        err_clr = 1'b1;
        cyc(1'b0, 1'b1, 8'h00);
        err_clr = 1'b0;
        chk_level("rd_empty", 0);
        chk("rd_empty_unf_set_wins", 32'(underflow), 32'(ERR));
        err_clr = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        err_clr = 1'b0;
        chk("unf_clr2", 32'(underflow), 32'(0));

        // Fill 0x01..0x10.
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, 1'b0, 8'(i));
            chk_level($sformatf("fill%0d", i), i);
            chk($sformatf("fill%0d_dout", i), 32'(dout), 32'h01);
        end

        // Write while full is dropped.
        cyc(1'b1, 1'b0, 8'hAA);
        chk_level("ovf", 16);
        chk("ovf_dout", 32'(dout), 32'h01);
        chk("ovf_flag", 32'(overflow), 32'(ERR));
        err_clr = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        err_clr = 1'b0;
        chk("ovf_clr", 32'(overflow), 32'(0));

        // Drain in order.
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("drain%0d_dout", i), 32'(dout), 32'(i));
            cyc(1'b0, 1'b1, 8'h00);
            chk_level($sformatf("drain%0d", i), 16 - i);
        end
        chk("drain_unf", 32'(underflow), 32'(0));

        // Refill, then push-through while full.
        for (int i = 1; i <= 16; i++) cyc(1'b1, 1'b0, 8'(i));
        chk_level("refill", 16);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 8'h77);
            chk_level($sformatf("thru%0d", i), 16);
            chk($sformatf("thru%0d_dout", i), 32'(dout), 32'(i + 2));
        end
        chk("thru_ovf", 32'(overflow), 32'(0));
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("drain2_%0d_dout", k), 32'(dout), (k < 13) ? 32'(k + 4) : 32'h77);
            cyc(1'b0, 1'b1, 8'h00);
        end
        chk_level("drain2_end", 0);

        // Asynchronous reset mid-cycle, then resume.
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'hC0 + i));
        chk_level("pre_rst", 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk_level("async_rst", 0);
        chk("async_rst_ovf", 32'(overflow), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, 8'h33);
        chk_level("post_rst", 1);
        chk("post_rst_dout", 32'(dout), 32'h33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
